ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter: DW, 16, datapath width of ALU result, store data, PC+2 and retire counter.
REQ-002 Parameter: RW, 3, register-specifier width.
REQ-003 Ports (clock and reset first; one clock; rst asynchronous, active-low):
 clk  in  1  rising-edge clock
 rst  in  1  async active-low reset
 stall  in  1  hold all state this cycle
 flush  in  1  replace incoming instruction with bubble
 ex_valid  in  1  EX holds a real instruction
 ex_alu_result  in  DW  effective address / ALU result
 ex_store_data  in  DW  store operand
 ex_memread  in  1  load
 ex_memwrite  in  1  store
 ex_regwrite  in  1  writes register file
 ex_wb_reg  in  RW  destination register
 ex_halt  in  1  HALT instruction
 ex_pc_plus2  in  DW  PC+2 for link writes
 mem_valid  out  1  MEM holds a real instruction
 ALU_in  out  DW  address to data memory
 alu_operand2before  out  DW  store data to data memory
 MEMREAD  out  1  gated load enable
 MEMWRITE  out  1  gated store enable
 HALT  out  1  one-shot dump request to data memory
 mem_regwrite  out  1  gated regwrite
 mem_wb_reg  out  RW  destination register
 mem_pc_plus2  out  DW  latched PC+2
 halted  out  1  sticky: HALT has fired
 retired  out  DW  count of valid instructions entering MEM

Function
REQ-004 Block SHALL be the EX/MEM pipeline register plus halt sequencing and retire counting.
REQ-005 Edge priority SHALL be: rst, then halted, then stall, then flush, then load.
REQ-006 Load (no stall, no flush, halted=0): all fields SHALL capture EX inputs; mem_valid <= ex_valid.
REQ-007 Stall: every register including retired SHALL hold; stall overrides flush.
REQ-008 Flush without stall: mem_valid SHALL become 0; data fields (ALU_in, alu_operand2before, mem_wb_reg, mem_pc_plus2) SHALL load normally; retired unchanged.
REQ-009 MEMREAD, MEMWRITE, mem_regwrite SHALL be registered control bits ANDed combinationally with mem_valid and ~halted; bubble never touches memory or register file.
REQ-010 HALT SHALL equal mem_valid & latched_halt & ~halted (combinational), so it is high for exactly one cycle per halt even under stall.
REQ-011 halted SHALL set on the rising edge where HALT=1, regardless of stall or flush, and clear only by reset.
REQ-012 While halted=1 the register SHALL load a bubble every cycle (mem_valid=0, controls 0), ignoring ex_* , stall and flush.
REQ-013 retired SHALL increment by 1 on each edge that loads with ex_valid=1, flush=0, stall=0, halted=0; saturate at all-ones (no wrap).
REQ-014 Latency: EX inputs SHALL appear on outputs exactly one clock after capture edge.
REQ-015 ex_memread and ex_memwrite both 1 SHALL be passed through unchanged (decoder's responsibility); memory sees write.
REQ-016 Simultaneous ex_halt with ex_memwrite SHALL perform the write in same cycle HALT fires.

Reset
REQ-017 rst=0 SHALL asynchronously clear all registers: every output 0, including halted and retired.
REQ-018 Reset asserted mid-stall or mid-halt SHALL abort immediately; first edge after rst rises SHALL behave as normal load.

Verification
REQ-019 Load: ex_valid=1, ex_alu_result=16'h0040, ex_memwrite=1, ex_store_data=16'hBEEF -> next cycle ALU_in=0040, alu_operand2before=BEEF, MEMWRITE=1, retired=1.
REQ-020 Stall hold: after REQ-019, stall=1 for 3 cycles with new EX data -> outputs and retired unchanged all 3 cycles.
REQ-021 Flush: ex_valid=1, ex_regwrite=1, ex_memread=1, flush=1 -> next cycle mem_valid=0, MEMREAD=0, mem_regwrite=0, retired unchanged.
REQ-022 Halt under stall: ex_halt=1 loaded, then stall=1 for 2 cycles -> HALT=1 for exactly first cycle, halted=1 thereafter, MEMWRITE/MEMREAD=0 while stalled.
REQ-023 Saturation: preload retired to 16'hFFFF via 65535 valid loads -> further valid load leaves retired=FFFF.
REQ-024 Async reset: rst pulsed low between clock edges with halted=1 -> all outputs 0 before next edge; next valid load sets retired=1.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with halt sequencing and retire counting.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   stall, flush        hold everything / replace the incoming instruction with a bubble
//   ex_*                instruction fields presented by the EX stage
//   mem_valid           MEM holds a real instruction
//   ALU_in              data-memory address
//   alu_operand2before  data-memory store data
//   MEMREAD, MEMWRITE   memory enables, gated by mem_valid and ~halted
//   mem_regwrite        register-file write enable, gated the same way
//   HALT                one-cycle dump request to data memory
//   mem_wb_reg          destination register
//   mem_pc_plus2        latched PC+2 for link writes
//   halted              sticky flag, set once HALT has fired
//   retired             saturating count of valid instructions entering MEM
module ex_mem_reg #(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          ex_valid,
   input  logic [DW-1:0] ex_alu_result,
   input  logic [DW-1:0] ex_store_data,
   input  logic          ex_memread,
   input  logic          ex_memwrite,
   input  logic          ex_regwrite,
   input  logic [RW-1:0] ex_wb_reg,
   input  logic          ex_halt,
   input  logic [DW-1:0] ex_pc_plus2,
   output logic          mem_valid,
   output logic [DW-1:0] ALU_in,
   output logic [DW-1:0] alu_operand2before,
   output logic          MEMREAD,
   output logic          MEMWRITE,
   output logic          HALT,
   output logic          mem_regwrite,
   output logic [RW-1:0] mem_wb_reg,
   output logic [DW-1:0] mem_pc_plus2,
   output logic          halted,
   output logic [DW-1:0] retired
);

   logic memread_q;
   logic memwrite_q;
   logic regwrite_q;
   logic halt_q;
   logic halt_fire_c;

   // Control bits only reach memory / register file for a real, non-halted instruction.
   // HALT drops the cycle after it fires because halted is set on that edge, even if stalled.
   assign halt_fire_c  = mem_valid & halt_q & ~halted;
   assign HALT         = halt_fire_c;
   assign MEMREAD      = memread_q  & mem_valid & ~halted;
   assign MEMWRITE     = memwrite_q & mem_valid & ~halted;
   assign mem_regwrite = regwrite_q & mem_valid & ~halted;

   // Pipeline register: priority is reset, halted, stall, flush, load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid          <= 1'b0;
         ALU_in             <= '0;
         alu_operand2before <= '0;
         memread_q          <= 1'b0;
         memwrite_q         <= 1'b0;
         regwrite_q         <= 1'b0;
         halt_q             <= 1'b0;
         mem_wb_reg         <= '0;
         mem_pc_plus2       <= '0;
         halted             <= 1'b0;
         retired            <= '0;
      end else if (halted) begin
         // Halted machine keeps loading bubbles; EX, stall and flush are ignored.
         mem_valid  <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         regwrite_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         if (halt_fire_c) begin
            halted <= 1'b1;
         end
         if (!stall) begin
            ALU_in             <= ex_alu_result;
            alu_operand2before <= ex_store_data;
            mem_wb_reg         <= ex_wb_reg;
            mem_pc_plus2       <= ex_pc_plus2;
            if (flush) begin
               mem_valid  <= 1'b0;
               memread_q  <= 1'b0;
               memwrite_q <= 1'b0;
               regwrite_q <= 1'b0;
               halt_q     <= 1'b0;
            end else begin
               mem_valid  <= ex_valid;
               memread_q  <= ex_memread;
               memwrite_q <= ex_memwrite;
               regwrite_q <= ex_regwrite;
               halt_q     <= ex_halt;
               // Saturating retire count.
               if (ex_valid && (retired != '1)) begin
                  retired <= retired + DW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: scoreboard bench for ex_mem_reg with a cycle-level reference model.
module tb_ex_mem_reg;
   localparam int unsigned DW = 16;
   localparam int unsigned RW = 3;

   logic          clk;
   logic          rst;
   logic          stall, flush, ex_valid, ex_memread, ex_memwrite, ex_regwrite, ex_halt;
   logic [DW-1:0] ex_alu_result, ex_store_data, ex_pc_plus2;
   logic [RW-1:0] ex_wb_reg;
   logic          mem_valid, MEMREAD, MEMWRITE, HALT, mem_regwrite, halted;
   logic [DW-1:0] ALU_in, alu_operand2before, mem_pc_plus2, retired;
   logic [RW-1:0] mem_wb_reg;

   ex_mem_reg #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
      .ex_wb_reg(ex_wb_reg), .ex_halt(ex_halt), .ex_pc_plus2(ex_pc_plus2),
      .mem_valid(mem_valid), .ALU_in(ALU_in), .alu_operand2before(alu_operand2before),
      .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .HALT(HALT), .mem_regwrite(mem_regwrite),
      .mem_wb_reg(mem_wb_reg), .mem_pc_plus2(mem_pc_plus2), .halted(halted),
      .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] alu;
      logic [DW-1:0] sd;
      logic          rd;
      logic          wr;
      logic          halt;
      logic          rw;
      logic [RW-1:0] wb;
      logic [DW-1:0] pc;
      logic          halted;
      logic [DW-1:0] ret;
   } out_t;

   typedef struct {
      logic          stall, flush, valid, rd, wr, rw, halt;
      logic [DW-1:0] alu, sd, pc;
      logic [RW-1:0] wb;
   } in_t;

   typedef struct {
      int   cyc;
      out_t o;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;

   // Reference model: the instruction currently sitting in MEM plus machine status.
   logic          m_valid, m_rd, m_wr, m_rw, m_halt, m_halted;
   logic [DW-1:0] m_alu, m_sd, m_pc;
   logic [RW-1:0] m_wb;
   int            m_ret;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic out_t dut_out();
      out_t o;
      o = '{valid: mem_valid, alu: ALU_in, sd: alu_operand2before, rd: MEMREAD,
            wr: MEMWRITE, halt: HALT, rw: mem_regwrite, wb: mem_wb_reg,
            pc: mem_pc_plus2, halted: halted, ret: retired};
      return o;
   endfunction

   function automatic out_t model_out();
      out_t o;
      logic live;
      live = m_valid && !m_halted;
      o = '{valid: m_valid, alu: m_alu, sd: m_sd, rd: live && m_rd, wr: live && m_wr,
            halt: live && m_halt, rw: live && m_rw, wb: m_wb, pc: m_pc,
            halted: m_halted, ret: DW'(m_ret)};
      return o;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_halt = 0; m_halted = 0;
      m_alu = '0; m_sd = '0; m_pc = '0; m_wb = '0; m_ret = 0;
   endtask

   // One clock edge of the model, applying the documented priority order.
   task automatic model_edge(input in_t i);
      logic fire;
      fire = m_valid && m_halt && !m_halted;
      if (m_halted) begin
         m_valid = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_halt = 0;
      end else if (!i.stall) begin
         m_alu = i.alu; m_sd = i.sd; m_pc = i.pc; m_wb = i.wb;
         m_rd = i.rd; m_wr = i.wr; m_rw = i.rw; m_halt = i.halt;
         m_valid = i.valid && !i.flush;
         if (m_valid && m_ret < 65535) m_ret = m_ret + 1;
      end
      if (fire) m_halted = 1;
   endtask

   task automatic check_out(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Monitor: compare the DUT against the expectation due for the current cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
         e = sb.pop_front();
         if (e.cyc < cyc_cnt) begin
            checks++;
            failures++;
            $display("FAIL stale_expectation cyc=%0d now=%0d", e.cyc, cyc_cnt);
         end else begin
            check_out("pipeline_outputs", dut_out(), e.o);
         end
      end
   end

   // Called at posedge+#1 (or just after reset release); applies inputs for the next edge.
   task automatic drive(input in_t i);
      exp_t e;
      stall = i.stall; flush = i.flush; ex_valid = i.valid;
      ex_alu_result = i.alu; ex_store_data = i.sd; ex_pc_plus2 = i.pc;
      ex_memread = i.rd; ex_memwrite = i.wr; ex_regwrite = i.rw;
      ex_wb_reg = i.wb; ex_halt = i.halt;
      model_edge(i);
      e.cyc = cyc_cnt + 1;
      e.o   = model_out();
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   function automatic in_t idle_in();
      in_t i;
      i = '{stall: 0, flush: 0, valid: 0, rd: 0, wr: 0, rw: 0, halt: 0,
            alu: '0, sd: '0, pc: '0, wb: '0};
      return i;
   endfunction

   function automatic in_t rand_in(input bit allow_halt);
      in_t i;
      i.stall = ($urandom_range(0, 4) == 0);
      i.flush = ($urandom_range(0, 5) == 0);
      i.valid = ($urandom_range(0, 3) != 0);
      i.rd    = 1'($urandom);
      i.wr    = 1'($urandom);
      i.rw    = 1'($urandom);
      i.halt  = allow_halt && ($urandom_range(0, 39) == 0);
      i.alu   = DW'($urandom);
      i.sd    = DW'($urandom);
      i.pc    = DW'($urandom);
      i.wb    = RW'($urandom);
      return i;
   endfunction

   // Reset pulse strictly between edges; outputs must clear before the next edge.
   task automatic async_reset(input string name);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check_out(name, dut_out(), out_t'('0));
      model_clear();
      #1 rst = 1'b1;
   endtask

   initial begin
      in_t i;
      int  halt_age;
      rst = 1'b0;
      drive_idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1 check_out("reset_state", dut_out(), out_t'('0));
      @(negedge clk);
      rst = 1'b1;

      // Basic store load, then a 3-cycle stall with fresh EX data.
      i = idle_in(); i.valid = 1; i.alu = 16'h0040; i.wr = 1; i.sd = 16'hBEEF; i.pc = 16'h0012;
      drive(i);
      check_val("load_alu_in", ALU_in, 16'h0040);
      check_val("load_store_data", alu_operand2before, 16'hBEEF);
      check_val("load_memwrite", DW'(MEMWRITE), DW'(1));
      check_val("load_retired", retired, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         i = rand_in(0); i.stall = 1; i.valid = 1; i.flush = (k == 1);
         drive(i);
         check_val("stall_alu_in", ALU_in, 16'h0040);
         check_val("stall_retired", retired, 16'h0001);
      end

      // Flush turns a valid load/regwrite instruction into a bubble.
      i = idle_in(); i.valid = 1; i.rw = 1; i.rd = 1; i.flush = 1; i.alu = 16'h1234;
      drive(i);
      check_val("flush_valid", DW'(mem_valid), DW'(0));
      check_val("flush_memread", DW'(MEMREAD), DW'(0));
      check_val("flush_retired", retired, 16'h0001);

      // Both read and write pass through unchanged.
      i = idle_in(); i.valid = 1; i.rd = 1; i.wr = 1; i.alu = 16'h0002;
      drive(i);

      // Halt together with a store, then stalled for two cycles.
      i = idle_in(); i.valid = 1; i.halt = 1; i.wr = 1; i.alu = 16'h00F0; i.sd = 16'h5A5A;
      drive(i);
      check_val("halt_fires", DW'(HALT), DW'(1));
      check_val("halt_store_same_cycle", DW'(MEMWRITE), DW'(1));
      i = rand_in(0); i.stall = 1;
      drive(i);
      check_val("halt_one_shot", DW'(HALT), DW'(0));
      check_val("halted_sticky", DW'(halted), DW'(1));
      check_val("halted_memwrite_off", DW'(MEMWRITE), DW'(0));
      drive(i);
      for (int k = 0; k < 3; k++) drive(rand_in(1));

      // Reset while halted, then a valid load counts from zero again.
      async_reset("reset_while_halted");
      i = idle_in(); i.valid = 1; i.alu = 16'h0100;
      drive(i);
      check_val("post_reset_retired", retired, 16'h0001);

      // Random traffic; leave the halted state via reset after a few cycles.
      halt_age = 0;
      for (int n = 0; n < 3000; n++) begin
         drive(rand_in(1));
         halt_age = m_halted ? halt_age + 1 : 0;
         if (halt_age > 4 || $urandom_range(0, 299) == 0) begin
            async_reset("random_reset");
            halt_age = 0;
         end
      end

      // Retire counter saturation.
      async_reset("reset_before_saturation");
      i = idle_in(); i.valid = 1;
      for (int n = 0; n < 65535; n++) begin
         i.alu = DW'(n);
         drive(i);
      end
      check_val("retired_at_max", retired, 16'hFFFF);
      drive(i);
      check_val("retired_saturates", retired, 16'hFFFF);

      for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic drive_idle_inputs();
      stall = 0; flush = 0; ex_valid = 0; ex_memread = 0; ex_memwrite = 0;
      ex_regwrite = 0; ex_halt = 0; ex_alu_result = '0; ex_store_data = '0;
      ex_pc_plus2 = '0; ex_wb_reg = '0;
   endtask

endmodule
